cordic_sum_sequencer: RTL and testbench

//  Initiator side of the start/done custom-instruction handshake used by the CORDIC+adder

---
 rtl/cordic_sum_sequencer.sv | 130 +++++++++++++
 tb/tb_cordic_sum_sequencer.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cordic_sum_sequencer.sv
// Start/done initiator for the CORDIC+adder unit: issues one instruction per operand and chains each result into the next datab.
// Optional WAIT-state watchdog enabled with `define CI_TIMEOUT_EN.
module cordic_sum_sequencer #(
  parameter logic [31:0] INIT_SUM       = 32'h0000_0000,
  parameter int          TIMEOUT_CYCLES = 255,
  parameter int          CNT_W          = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  input  logic [31:0]      in_data,
  input  logic             in_last,
  output logic             in_ready,
  output logic             ci_start,
  output logic [31:0]      ci_dataa,
  output logic [31:0]      ci_datab,
  input  logic [31:0]      ci_result,
  input  logic             ci_done,
  output logic             sum_valid,
  output logic [31:0]      sum_data,
  output logic [CNT_W-1:0] elem_count,
  output logic             busy,
  output logic             err
);

  localparam int DATA_W = 32;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_FINISH} state_t;

  state_t            state, state_nxt;
  logic [DATA_W-1:0] x_q;
  logic [DATA_W-1:0] sum_q;
  logic [DATA_W-1:0] sum_out_q;
  logic              last_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              timeout;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

`ifdef CI_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [WD_W-1:0] wd_q;
  logic            err_q;

  assign timeout = (state == S_WAIT) && !ci_done && (wd_q == WD_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wd_q  <= '0;
      err_q <= 1'b0;
    end else begin
      if (state == S_ISSUE)
        wd_q <= '0;
      else if (state == S_WAIT && !ci_done && !timeout)
        wd_q <= wd_q + {{(WD_W-1){1'b0}}, 1'b1};
      if (timeout)
        err_q <= 1'b1;
    end
  end

  assign err = err_q;
`else
  assign timeout = 1'b0;
  assign err     = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      x_q       <= '0;
      last_q    <= 1'b0;
      sum_q     <= INIT_SUM;
      cnt_q     <= '0;
      sum_out_q <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            x_q    <= in_data;
            last_q <= in_last;
          end
        end
        S_WAIT: begin
          if (ci_done) begin
            sum_q <= ci_result;
            cnt_q <= sat_inc(cnt_q);
            if (last_q)
              sum_out_q <= ci_result;
          end else if (timeout) begin
            // Watchdog abort reports the last sum the slave actually returned
            sum_out_q <= sum_q;
          end
        end
        S_FINISH: begin
          sum_q <= INIT_SUM;
          cnt_q <= '0;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (in_valid) state_nxt = S_ISSUE;
      S_ISSUE:  state_nxt = S_WAIT;
      S_WAIT: begin
        if (ci_done)      state_nxt = last_q ? S_FINISH : S_IDLE;
        else if (timeout) state_nxt = S_FINISH;
      end
      S_FINISH: state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  assign in_ready   = (state == S_IDLE);
  assign ci_start   = (state == S_ISSUE);
  assign ci_dataa   = x_q;
  assign ci_datab   = sum_q;
  assign sum_valid  = (state == S_FINISH);
  assign sum_data   = sum_out_q;
  assign elem_count = cnt_q;
  assign busy       = (state != S_IDLE);

endmodule

// File: tb/tb_cordic_sum_sequencer.sv
// Scoreboard bench for cordic_sum_sequencer with a latency-configurable cos(a)+b slave model.
module tb_cordic_sum_sequencer;
  localparam int          CNT_W = 2;
  localparam logic [31:0] PI_F  = 32'h4049_0FDB;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             in_valid = 1'b0;
  logic [31:0]      in_data = '0;
  logic             in_last = 1'b0;
  logic             in_ready;
  logic             ci_start;
  logic [31:0]      ci_dataa;
  logic [31:0]      ci_datab;
  logic [31:0]      ci_result = '0;
  logic             ci_done = 1'b0;
  logic             sum_valid;
  logic [31:0]      sum_data;
  logic [CNT_W-1:0] elem_count;
  logic             busy;
  logic             err;

  cordic_sum_sequencer #(
    .INIT_SUM(32'h0000_0000),
    .TIMEOUT_CYCLES(16),
    .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
    .ci_start(ci_start), .ci_dataa(ci_dataa), .ci_datab(ci_datab),
    .ci_result(ci_result), .ci_done(ci_done),
    .sum_valid(sum_valid), .sum_data(sum_data), .elem_count(elem_count),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  logic [63:0]      exp_start[$];
  logic [31:0]      exp_sum[$];
  logic [CNT_W-1:0] exp_cnt[$];
  logic [31:0]      elems[$];

  int bfm_lat   = 1;
  bit bfm_never = 1'b0;
  int spur_req  = 0;
  int acc_cyc   = 0;

  // Small-integer float table: every running sum in these vectors is a whole number.
  function automatic int f2i(input logic [31:0] f);
    case (f)
      32'h0000_0000, 32'h8000_0000: return 0;
      32'h3F80_0000: return 1;
      32'h4000_0000: return 2;
      32'h4040_0000: return 3;
      32'h4080_0000: return 4;
      32'h40A0_0000: return 5;
      32'hBF80_0000: return -1;
      32'hC000_0000: return -2;
      default:       return 99;
    endcase
  endfunction

  function automatic logic [31:0] i2f(input int i);
    case (i)
      0:       return 32'h0000_0000;
      1:       return 32'h3F80_0000;
      2:       return 32'h4000_0000;
      3:       return 32'h4040_0000;
      4:       return 32'h4080_0000;
      5:       return 32'h40A0_0000;
      -1:      return 32'hBF80_0000;
      -2:      return 32'hC000_0000;
      default: return 32'h7FC0_0000;
    endcase
  endfunction

  function automatic int cos_i(input logic [31:0] a);
    if (a == 32'h0000_0000) return 1;
    if (a == PI_F)          return -1;
    return 99;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // Slave model: done L cycles after the start pulse, result computed from the held operands.
  initial begin : bfm
    int pend;
    int spur_seen;
    pend = 0;
    spur_seen = 0;
    forever begin
      @(negedge clk);
      ci_done = 1'b0;
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          ci_done   = 1'b1;
          ci_result = i2f(f2i(ci_datab) + cos_i(ci_dataa));
        end
      end
      if (spur_req != spur_seen) begin
        spur_seen++;
        ci_done   = 1'b1;
        ci_result = 32'h4120_0000;
      end
      if (ci_start && !bfm_never) pend = bfm_lat;
    end
  end

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (ci_start) begin
        if (exp_start.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL start_unexpected: got ci_start with dataa=%h datab=%h, required none", ci_dataa, ci_datab);
        end else begin
          chk("start_operands", {ci_dataa, ci_datab}, exp_start.pop_front());
        end
      end
      if (sum_valid) begin
        if (exp_sum.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL sum_unexpected: got sum_valid with sum_data=%h, required none", sum_data);
        end else begin
          chk("sum_data", 64'(sum_data), 64'(exp_sum.pop_front()));
          chk("elem_count_at_sum", 64'(elem_count), 64'(exp_cnt.pop_front()));
        end
      end
    end
  end

  task automatic send(input logic [31:0] a, input bit last);
    int k = 0;
    in_valid = 1'b1;
    in_data  = a;
    in_last  = last;
    while (!in_ready && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (!in_ready) begin
      n_vec++; n_err++;
      $display("FAIL accept_timeout: got in_ready=0 for %0d cycles, required 1", k);
    end
    acc_cyc = cyc;
    @(negedge clk);
  endtask

  task automatic run_stream(input int lat, input bit hold);
    int s = 0;
    int n = elems.size();
    bfm_lat = lat;
    foreach (elems[i]) begin
      exp_start.push_back({elems[i], i2f(s)});
      s += cos_i(elems[i]);
    end
    exp_sum.push_back(i2f(s));
    exp_cnt.push_back((n >= (1 << CNT_W)) ? {CNT_W{1'b1}} : CNT_W'(n));
    foreach (elems[i]) send(elems[i], i == n - 1);
    if (!hold) begin
      in_valid = 1'b0;
      in_last  = 1'b0;
    end
  endtask

  task automatic wait_idle(input int maxc);
    int k = 0;
    while (busy && k < maxc) begin
      @(negedge clk);
      k++;
    end
    if (busy) begin
      n_vec++; n_err++;
      $display("FAIL idle_timeout: got busy=1 after %0d cycles, required 0", k);
    end
  endtask

  task automatic wait_sum(output int c);
    int k = 0;
    while (!sum_valid && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (!sum_valid) begin
      n_vec++; n_err++;
      $display("FAIL sum_timeout: got no sum_valid in %0d cycles, required one", k);
    end
    c = cyc;
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL global_timeout: got no end of test, required $finish");
    $fatal(1, "bench timeout");
  end

  initial begin : stim
    int c;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready",   64'(in_ready),   64'd1);
    chk("rst_busy",       64'(busy),       64'd0);
    chk("rst_sum_valid",  64'(sum_valid),  64'd0);
    chk("rst_ci_start",   64'(ci_start),   64'd0);
    chk("rst_ci_datab",   64'(ci_datab),   64'h0);
    chk("rst_elem_count", 64'(elem_count), 64'd0);
    chk("rst_err",        64'(err),        64'd0);
    chk("rst_sum_data",   64'(sum_data),   64'h0);

    elems = '{32'h0, 32'h0, 32'h0};
    run_stream(5, 1'b0);
    wait_idle(100);
    chk("count_cleared", 64'(elem_count), 64'd0);
    chk("sum_reinit",    64'(ci_datab),   64'h0);

    // Latency counted inclusively from the accepting cycle to the sum_valid cycle
    elems = '{32'h0};
    run_stream(1, 1'b0);
    wait_sum(c);
    chk("single_latency", 64'(c - acc_cyc + 1), 64'd4);
    wait_idle(50);

    elems = '{PI_F, 32'h0};
    run_stream(2, 1'b1);
    elems = '{32'h0, 32'h0, PI_F};
    run_stream(3, 1'b0);
    wait_idle(100);

    elems = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    run_stream(1, 1'b0);
    wait_idle(100);

    spur_req++;
    repeat (4) @(negedge clk);
    chk("spur_datab", 64'(ci_datab),   64'h0);
    chk("spur_count", 64'(elem_count), 64'd0);
    chk("spur_busy",  64'(busy),       64'd0);

    bfm_lat = 8;
    exp_start.push_back({32'h0, 32'h0});
    send(32'h0, 1'b1);
    in_valid = 1'b0;
    in_last  = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_wait_busy", 64'(busy), 64'd1);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("late_done_datab", 64'(ci_datab),   64'h0);
    chk("late_done_count", 64'(elem_count), 64'd0);
    chk("late_done_ready", 64'(in_ready),   64'd1);

    elems = '{PI_F};
    run_stream(2, 1'b0);
    wait_idle(50);

`ifdef CI_TIMEOUT_EN
    bfm_lat = 2;
    exp_start.push_back({32'h0, 32'h0});
    send(32'h0, 1'b0);
    in_valid = 1'b0;
    wait_idle(50);
    bfm_never = 1'b1;
    exp_start.push_back({32'h0, 32'h3F80_0000});
    exp_sum.push_back(32'h3F80_0000);
    exp_cnt.push_back(CNT_W'(1));
    send(32'h0, 1'b1);
    in_valid = 1'b0;
    in_last  = 1'b0;
    wait_sum(c);
    chk("timeout_err",    64'(err),         64'd1);
    chk("timeout_cycles", 64'(c - acc_cyc), 64'd18);
    @(negedge clk);
    chk("timeout_idle",   64'(in_ready),    64'd1);
    chk("timeout_busy",   64'(busy),        64'd0);
    bfm_never = 1'b0;
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
`endif

    repeat (3) @(negedge clk);
    chk("final_err",      64'(err),              64'd0);
    chk("pending_starts", 64'(exp_start.size()), 64'd0);
    chk("pending_sums",   64'(exp_sum.size()),   64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
